// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//   - ALU control codes. The same codes are used by ALU_control. Only
//     ALU_MUL and ALU_DIV are acted on by muldiv_sequencer.
//   - state_t: sequencer FSM states.
package muldiv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// Single combinational iteration of the multiply/divide datapath.
//   mode_div_i  0 = shift-add multiply step, 1 = restoring divide step
//   rem_i/o     WIDTH+1 bit upper accumulator / partial remainder
//   quo_i/o     WIDTH bit lower register (multiplier bits shift out,
//               quotient bits shift in)
//   b_i         multiplicand / divisor magnitude
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             mode_div_i,
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        // Multiply: the upper half never exceeds WIDTH bits, so the WIDTH+1 bit
        // sum keeps the carry. The sum then shifts right into the low half.
        sum     = rem_i + (quo_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
        // Divide: bring down the next dividend bit and trial-subtract. The extra
        // bit of diff is the borrow, and a set borrow means restore.
        shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, b_i};
        if (mode_div_i) begin
            rem_o = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
            quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH+1]};
        end else begin
            rem_o = {1'b0, sum[WIDTH:1]};
            quo_o = {sum[0], quo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer with MIPS-style HI/LO results.
// It iterates one bit per cycle, for WIDTH cycles.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request, sampled only in IDLE
//   alu_ctrl       ALU_MUL / ALU_DIV accepted; all other codes are ignored
//   op_signed      signed select; honoured only when MULDIV_SIGNED_EN is defined
//   op_a, op_b     multiplicand/dividend, multiplier/divisor
//   busy           iteration in progress (pipeline stall)
//   done           one-cycle pulse; hi/lo are valid from this cycle
//   hi, lo         mul: product upper/lower; div: remainder/quotient
//   div_zero       last div had op_b == 0; held until the next accepted start
// Build option: MULDIV_SIGNED_EN adds magnitude conversion on accept and
// sign-fixes the result on the edge that enters DONE.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_ctrl,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]     step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   rem_src, rem_fix, quo_fix;
    logic [2*WIDTH-1:0] prod_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_div_i (state_q == DIV),
        .rem_i      (rem_q),
        .quo_i      (quo_q),
        .b_i        (b_q),
        .rem_o      (step_rem),
        .quo_o      (step_quo)
    );

    // For a divide by zero, quo_q still holds the dividend. That value
    // becomes the remainder, so hi returns op_a.
    assign rem_src = (b_q == '0) ? quo_q : step_rem[WIDTH-1:0];

`ifdef MULDIV_SIGNED_EN
    logic neg_res_q, neg_res_d;   // negate the product or quotient
    logic neg_rem_q, neg_rem_d;   // the remainder follows the dividend sign
    logic a_neg, b_neg;

    assign a_neg    = op_signed & op_a[WIDTH-1];
    assign b_neg    = op_signed & op_b[WIDTH-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;
    assign prod_fix = neg_res_q ? -{step_rem[WIDTH-1:0], step_quo}
                                :  {step_rem[WIDTH-1:0], step_quo};
    assign quo_fix  = neg_res_q ? -step_quo : step_quo;
    assign rem_fix  = neg_rem_q ? -rem_src : rem_src;
`else
    logic unused_op_signed;
    assign unused_op_signed = op_signed;
    assign a_mag    = op_a;
    assign b_mag    = op_b;
    assign prod_fix = {step_rem[WIDTH-1:0], step_quo};
    assign quo_fix  = step_quo;
    assign rem_fix  = rem_src;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        busy    = 1'b0;
        done    = 1'b0;
`ifdef MULDIV_SIGNED_EN
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && (alu_ctrl == ALU_MUL || alu_ctrl == ALU_DIV)) begin
                    state_d = (alu_ctrl == ALU_MUL) ? MUL : DIV;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    rem_d   = '0;
                    quo_d   = a_mag;
                    b_d     = b_mag;
                    dz_d    = 1'b0;
`ifdef MULDIV_SIGNED_EN
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
`endif
                end
            end
            MUL: begin
                busy  = 1'b1;
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d      = DONE;
                    {hi_d, lo_d} = prod_fix;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV: begin
                busy = 1'b1;
                if (b_q == '0) begin
                    state_d = DONE;
                    dz_d    = 1'b1;
                    hi_d    = rem_fix;
                    lo_d    = '1;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) begin
                        state_d = DONE;
                        hi_d    = rem_fix;
                        lo_d    = quo_fix;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            dz_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            b_q   <= b_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dz_q  <= dz_d;
        end
    end

`ifdef MULDIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`endif

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed, table-driven bench for muldiv_sequencer (WIDTH = 32).
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   alu_ctrl = 3'b000;
    logic         op_signed = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alu_ctrl  (alu_ctrl),
        .op_signed (op_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] ctrl;
        logic       sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        logic       exp_dz;
        int         lat;      // cycle (1 = after the accept edge) in which done is high
        int         inject;   // cycle in which a stray start is driven, 0 = none
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [2:0] ctrl, input logic sgn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el,
                       input logic dz, input int lat, input int inject);
        vec_t v;
        v.name = name; v.ctrl = ctrl; v.sgn = sgn; v.a = a; v.b = b;
        v.exp_hi = eh; v.exp_lo = el; v.exp_dz = dz; v.lat = lat; v.inject = inject;
        vecs.push_back(v);
    endtask

    task automatic run_op(input vec_t v);
        int  cyc;
        int  busy_cnt;
        bit  seen_done;
        bit  overlap;
        bit  moved;
        @(negedge clk);
        alu_ctrl  = v.ctrl;
        op_signed = v.sgn;
        op_a      = v.a;
        op_b      = v.b;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({v.name, " busy_c1"}, 64'(busy), 64'd1);
        check({v.name, " dz_clear_c1"}, 64'(div_zero), 64'd0);
        busy_cnt = 0; seen_done = 0; overlap = 0; moved = 0;
        while (cyc <= 200) begin
            if (busy && done) overlap = 1;
            if (busy && (hi !== prev_hi || lo !== prev_lo)) moved = 1;
            if (busy) busy_cnt++;
            if (done) begin
                seen_done = 1;
                break;
            end
            if (cyc == v.inject) begin
                alu_ctrl = ALU_DIV; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (!seen_done) begin
            checks++; errors++;
            $display("FAIL %s timeout: no done within 200 cycles", v.name);
        end else begin
            check({v.name, " latency"}, 64'(cyc), 64'(v.lat));
            check({v.name, " busy_cycles"}, 64'(busy_cnt), 64'(v.lat - 1));
            check({v.name, " busy_done_overlap"}, 64'(overlap), 64'd0);
            check({v.name, " hold_during_iter"}, 64'(moved), 64'd0);
            check({v.name, " hi"}, 64'(hi), 64'(v.exp_hi));
            check({v.name, " lo"}, 64'(lo), 64'(v.exp_lo));
            check({v.name, " div_zero"}, 64'(div_zero), 64'(v.exp_dz));
        end
        @(negedge clk);
        check({v.name, " done_pulse_end"}, 64'(done), 64'd0);
        check({v.name, " hi_hold"}, 64'(hi), 64'(v.exp_hi));
        check({v.name, " lo_hold"}, 64'(lo), 64'(v.exp_lo));
        prev_hi = v.exp_hi;
        prev_lo = v.exp_lo;
        $display("op %-14s ctrl=%b s=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d",
                 v.name, v.ctrl, v.sgn, v.a, v.b, hi, lo, div_zero, cyc);
    endtask

    initial begin
        bit saw;
        add("mul_7x6",     ALU_MUL, 1'b0, 32'd7,        32'd6,        32'd0,        32'd42,       1'b0, W+1, 0);
        add("mul_full",    ALU_MUL, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, W+1, 0);
        add("mul_shift",   ALU_MUL, 1'b0, 32'h12345678, 32'h10,       32'h1,        32'h23456780, 1'b0, W+1, 0);
        add("mul_carry",   ALU_MUL, 1'b0, 32'h80000000, 32'd2,        32'd1,        32'd0,        1'b0, W+1, 0);
        add("div_100_7",   ALU_DIV, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, W+1, 5);
        add("div_by_zero", ALU_DIV, 1'b0, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, 1'b1, 2,   0);
        add("mul_after_dz",ALU_MUL, 1'b0, 32'd7,        32'd6,        32'd0,        32'd42,       1'b0, W+1, 0);
        add("div_max_1",   ALU_DIV, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, W+1, 0);
        add("div_small",   ALU_DIV, 1'b0, 32'd5,        32'd9,        32'd5,        32'd0,        1'b0, W+1, 0);
        add("div_max_max", ALU_DIV, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, W+1, 0);
        add("div_msb_q",   ALU_DIV, 1'b0, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0, W+1, 0);
`ifdef MULDIV_SIGNED_EN
        add("smul_n7x6",   ALU_MUL, 1'b1, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, W+1, 0);
        add("sdiv_n7_2",   ALU_DIV, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, W+1, 0);
        add("sdiv_ovf",    ALU_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, W+1, 0);
        add("sdiv_zero",   ALU_DIV, 1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2,   0);
`endif

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst div_zero", 64'(div_zero), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset abort: results were non-zero before this point.
        @(negedge clk);
        alu_ctrl = ALU_MUL; op_signed = 1'b0; op_a = 32'd7; op_b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw = 1;
        end
        check("abort no_done_after", 64'(saw), 64'd0);
        $display("op %-14s reset asserted mid-mul -> busy=%0d hi=%h lo=%h", "reset_abort", busy, hi, lo);

        // A start with a non-mul/div code stays in IDLE.
        alu_ctrl = ALU_ADD; op_a = 32'd3; op_b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        saw = 0;
        repeat (5) begin
            if (busy || done) saw = 1;
            @(negedge clk);
        end
        check("add_ignored active", 64'(saw), 64'd0);
        check("add_ignored hi", 64'(hi), 64'd0);
        check("add_ignored lo", 64'(lo), 64'd0);
        $display("op %-14s ctrl=000 start -> busy=%0d done=%0d hi=%h lo=%h", "add_ignored", busy, done, hi, lo);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the multiply and divide operations selected by ALU control codes 3'b010 (mul) and 3'b011 (div).
- Sits beside the single-cycle ALU. Accepts a start pulse, iterates one bit per cycle, holds the pipeline through busy, and returns MIPS-style HI/LO results with a one-cycle done pulse.
- Stage ownership: the ALU still executes add/sub/and/or/xor; this block only owns mul/div.

Parameters:
- WIDTH, 32, operand width; hi/lo outputs are WIDTH bits each.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- alu_ctrl  input  3  ALU control code; 3'b010 = mul, 3'b011 = div; all other codes are ignored.
- op_signed  input  1  signed-operation select; only honoured when MULDIV_SIGNED_EN is defined.
- op_a  input  WIDTH  multiplicand / dividend.
- op_b  input  WIDTH  multiplier / divisor.
- busy  output  1  operation in progress; stall request to the pipeline.
- done  output  1  one-cycle pulse; hi/lo are valid from this cycle.
- hi  output  WIDTH  mul: upper product half; div: remainder.
- lo  output  WIDTH  mul: lower product half; div: quotient.
- div_zero  output  1  last div had op_b == 0; held until the next accepted start.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0; counter=0. Asserting reset mid-operation aborts immediately, with no done pulse and results cleared.
- States:
  - IDLE: start && alu_ctrl==010 -> MUL; start && alu_ctrl==011 -> DIV. Operands latch on the accepting edge; div_zero clears on that edge. Start with any other code: stay IDLE, no output change.
  - MUL: shift-add, one multiplier bit per cycle, for exactly WIDTH cycles; then -> DONE.
  - DIV: restoring division, one quotient bit per cycle, for exactly WIDTH cycles; then -> DONE. Divisor == 0: set div_zero, skip iteration, -> DONE after 1 cycle.
  - DONE: done=1 for exactly one cycle; hi/lo are updated on the edge entering DONE; then -> IDLE unconditionally.
- Latency:
  - busy rises on the edge after the start-sampling edge and stays high for WIDTH cycles (1 cycle for div-by-zero).
  - done is high during cycle WIDTH+1 after start (cycle 2 for div-by-zero).
  - busy and done are never high simultaneously.
- Start while busy or in DONE: ignored; the operands and operation in flight are unaffected.
- Results: hi/lo hold their value until the next accepted operation completes; they do not change during iteration.
- Divide by zero: hi = op_a, lo = all ones, div_zero = 1.
- Width rules:
  - Product is the full 2*WIDTH bits, no truncation.
  - Partial remainder register is WIDTH+1 bits.
  - Counter counts WIDTH-1 down to 0, with no wrap beyond 0.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined, op_signed=1:
  - Operands are converted to magnitudes on accept, and results are sign-fixed on the edge entering DONE (no extra cycle).
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Overflow case: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Divide by zero behaves as in the unsigned case.
- Defined, op_signed=0: unsigned.
- Undefined: op_signed is ignored and all operations are unsigned; no sign-fix logic is synthesised.

Decomposition:
- Package muldiv_pkg holds:
  - ALU control code localparams (ALU_ADD 000 through ALU_XOR 110, including ALU_MUL 010 and ALU_DIV 011), shared with ALU_control.
  - The state enum typedef (IDLE, MUL, DIV, DONE).
- Sub-module muldiv_step: combinational single-iteration step. Shift-add for mul, or trial-subtract/restore for div, selected by a mode bit. The sequencer instantiates it once.

Test Plan:
1. Mul basic: op_a=7, op_b=6, alu_ctrl=010 -> busy 32 cycles, then done pulse; hi=0, lo=42.
2. Mul full width: op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. Div: op_a=100, op_b=7, alu_ctrl=011 -> lo=14, hi=2, div_zero=0. A second start mid-operation (op_a=1, op_b=1) is ignored, and the results stay 14/2.
4. Div by zero: op_a=0x1234, op_b=0 -> done 2 cycles after start; hi=0x1234, lo=0xFFFFFFFF, div_zero=1. The next valid start clears div_zero.
5. Reset abort: rst_n low 10 cycles into a mul -> busy=0, hi=lo=0 immediately; no done pulse follows. A start with alu_ctrl=000 leaves the block in IDLE.
6. Signed (with MULDIV_SIGNED_EN, op_signed=1):
   - -7 * 6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6.
   - -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
